sprite_addr_gen: RTL
====================

Name: sprite_addr_gen

Overview:
Parametrised multi-sprite ROM address generator for the VGA display path. It supersedes the single-player fixed-column address generator. Each cycle it takes the current VGA scan position and finds the highest-priority enabled sprite covering that pixel. It then emits that sprite's block-ROM address, a hit flag and the sprite index. Sprite positions and per-sprite mirror/enable controls are latched once per frame so that game logic updates never tear mid-frame.

Parameters:
NUM_SPR, 2, number of sprites (1..8); index 0 has highest priority.
SPR_W, 30, sprite width in pixels.
SPR_H, 50, sprite height in pixels.
ADDR_W, 12, pixel_addr width; must satisfy 2^ADDR_W >= NUM_SPR*SPR_W*SPR_H.
LATCH_LINE, 480, v_cnt value at which positions are latched (first vblank line).
MISS_ADDR, 0, pixel_addr value driven when no sprite hits.

Ports:
clk  input  1  pixel clock; h_cnt/v_cnt advance once per cycle.
rst_n  input  1  asynchronous active-low reset.
h_cnt  input  10  current horizontal pixel (0..639 visible).
v_cnt  input  10  current vertical line (0..479 visible).
spr_x  input  10*NUM_SPR  packed left-edge X positions; sprite i occupies bits [10i+9:10i].
spr_y  input  10*NUM_SPR  packed top-edge Y positions; same packing as spr_x.
spr_en  input  NUM_SPR  per-sprite enable.
spr_flip  input  NUM_SPR  per-sprite horizontal mirror.
pixel_addr  output  ADDR_W  ROM address; registered.
pixel_hit  output  1  1 = pixel_addr is a sprite pixel; registered.
spr_id  output  3  index of the hit sprite, 0 when there is no hit; registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pixel_addr=MISS_ADDR, pixel_hit=0, spr_id=0.
  - All latched x/y = 0, latched en = 0, latched flip = 0. Nothing is displayed until the first latch.
- Latch:
  - On the rising clk edge where h_cnt==0 and v_cnt==LATCH_LINE, capture spr_x, spr_y, spr_en and spr_flip into shadow registers.
  - The shadow registers are held at all other times. Inputs may change arbitrarily between latches with no visible effect.
- Pipeline: 2 cycles of latency from an h_cnt/v_cnt sample to the matching outputs.
- Stage 1, registered:
  - For each sprite i, hit_i = en_i AND h >= x_i AND h < x_i+SPR_W AND v >= y_i AND v < y_i+SPR_H.
  - Compares use 11-bit sums, so x_i+SPR_W never wraps. A sprite partially beyond 639/479 is clipped naturally and never wraps to the left or top edge.
  - Priority encoder: the lowest i with hit_i=1 wins.
  - Register: any_hit, winning index, col = h - x_win, row = v - y_win (both narrowed to fit SPR_W/SPR_H), and flip_win.
- Stage 2, registered:
  - col_eff = flip ? (SPR_W-1-col) : col.
  - pixel_addr = win*SPR_W*SPR_H + row*SPR_W + col_eff, computed at ADDR_W bits with no modulo.
  - pixel_hit = any_hit; spr_id = win.
  - On a miss: pixel_addr=MISS_ADDR, spr_id=0, pixel_hit=0.
- Overlap: only the highest-priority sprite is shown; lower sprites are hidden with no blending.
- Sprite latched with en=0: never hits, whatever its position.
- Latch coinciding with a visible pixel: impossible when LATCH_LINE >= 480. If it occurs anyway, the stage-1 compare uses the pre-latch values for that cycle.
- Reset mid-frame: outputs return to reset values immediately. The first valid output pair appears 2 cycles after rst_n rises. Sprites stay hidden until the next latch line.
- No combinational path from any input to any output.

Test Plan:
- Reset then scan: rst_n low 3 cycles; apply h=520, v=100 with spr_en=2'b11 but no latch yet -> pixel_hit=0, pixel_addr=0 for the entire frame.
- Basic hit:
  - Setup: latch sprite0 at x=500, y=80, en=1.
  - h=500, v=80 -> 2 cycles later pixel_addr=0, hit=1, spr_id=0.
  - h=529, v=129 -> addr=1499.
  - h=530, v=80 -> hit=0.
- Second sprite and flip:
  - Setup: latch sprite1 at x=100, y=200, flip=1.
  - h=100, v=200 -> addr=1500+29=1529, spr_id=1.
  - h=129, v=201 -> addr=1500+30+0=1530.
- Overlap priority: both sprites at x=300, y=300 -> h=310, v=310 gives spr_id=0, addr=310. Then disable sprite0 and latch again -> spr_id=1, addr=1500+310=1810.
- Edge clipping: sprite0 at x=630, y=470 -> h=639, v=479 gives addr=9*30+9=279. h=0, v=470 gives hit=0, so there is no wraparound.
- Latch isolation: change spr_x from 500 to 200 at v=100 -> output unchanged until v=LATCH_LINE; on the next frame the hit appears at h=200.

Source files
------------

// File: rtl/sprite_addr_gen.sv
// Multi-sprite ROM address generator: per-frame latched sprite table, priority hit
// detection on the scan position, and a two-stage registered address pipeline.
module sprite_addr_gen #(
    parameter int NUM_SPR    = 2,
    parameter int SPR_W      = 30,
    parameter int SPR_H      = 50,
    parameter int ADDR_W     = 12,
    parameter int LATCH_LINE = 480,
    parameter int MISS_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            h_cnt,
    input  logic [9:0]            v_cnt,
    input  logic [10*NUM_SPR-1:0] spr_x,
    input  logic [10*NUM_SPR-1:0] spr_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [NUM_SPR-1:0]    spr_flip,
    output logic [ADDR_W-1:0]     pixel_addr,
    output logic                  pixel_hit,
    output logic [2:0]            spr_id
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [ADDR_W-1:0] L_SIZE    = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] L_WIDTH   = ADDR_W'(SPR_W);
    localparam logic [ADDR_W-1:0] L_MISS    = ADDR_W'(MISS_ADDR);
    localparam logic [CW-1:0]     L_COL_MAX = CW'(SPR_W - 1);
    localparam logic [9:0]        L_LATCH   = 10'(LATCH_LINE);
    localparam logic [10:0]       L_W11     = 11'(SPR_W);
    localparam logic [10:0]       L_H11     = 11'(SPR_H);

    logic [10*NUM_SPR-1:0] r_x;
    logic [10*NUM_SPR-1:0] r_y;
    logic [NUM_SPR-1:0]    r_en;
    logic [NUM_SPR-1:0]    r_flip;

    logic                  w_latch;
    logic [NUM_SPR-1:0]    w_hit;
    logic [CW-1:0]         w_dx [NUM_SPR];
    logic [RW-1:0]         w_dy [NUM_SPR];

    logic                  w_any;
    logic [2:0]            w_win;
    logic [CW-1:0]         w_col;
    logic [RW-1:0]         w_row;
    logic                  w_flip;

    logic                  r_s1_hit;
    logic [2:0]            r_s1_win;
    logic [CW-1:0]         r_s1_col;
    logic [RW-1:0]         r_s1_row;
    logic                  r_s1_flip;

    logic [CW-1:0]         w_col_eff;
    logic [ADDR_W-1:0]     w_addr;

    assign w_latch = (h_cnt == 10'd0) && (v_cnt == L_LATCH);

    // Shadow table; stage 1 reads the pre-latch values on the latch cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_en   <= '0;
            r_flip <= '0;
        end else if (w_latch) begin
            r_x    <= spr_x;
            r_y    <= spr_y;
            r_en   <= spr_en;
            r_flip <= spr_flip;
        end
    end

    // 11-bit compares so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            w_dx[i]  = CW'(h_cnt - r_x[10*i +: 10]);
            w_dy[i]  = RW'(v_cnt - r_y[10*i +: 10]);
            w_hit[i] = r_en[i]
                    && ({1'b0, h_cnt} >= {1'b0, r_x[10*i +: 10]})
                    && ({1'b0, h_cnt} <  ({1'b0, r_x[10*i +: 10]} + L_W11))
                    && ({1'b0, v_cnt} >= {1'b0, r_y[10*i +: 10]})
                    && ({1'b0, v_cnt} <  ({1'b0, r_y[10*i +: 10]} + L_H11));
        end
    end

    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_col  = '0;
        w_row  = '0;
        w_flip = 1'b0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (w_hit[i] && !w_any) begin
                w_any  = 1'b1;
                w_win  = 3'(i);
                w_col  = w_dx[i];
                w_row  = w_dy[i];
                w_flip = r_flip[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_hit  <= 1'b0;
            r_s1_win  <= '0;
            r_s1_col  <= '0;
            r_s1_row  <= '0;
            r_s1_flip <= 1'b0;
        end else begin
            r_s1_hit  <= w_any;
            r_s1_win  <= w_win;
            r_s1_col  <= w_col;
            r_s1_row  <= w_row;
            r_s1_flip <= w_flip;
        end
    end

    assign w_col_eff = r_s1_flip ? (L_COL_MAX - r_s1_col) : r_s1_col;
    assign w_addr    = ADDR_W'(r_s1_win) * L_SIZE
                     + ADDR_W'(r_s1_row) * L_WIDTH
                     + ADDR_W'(w_col_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_addr <= L_MISS;
            pixel_hit  <= 1'b0;
            spr_id     <= '0;
        end else begin
            pixel_addr <= r_s1_hit ? w_addr : L_MISS;
            pixel_hit  <= r_s1_hit;
            spr_id     <= r_s1_hit ? r_s1_win : 3'd0;
        end
    end

endmodule
